// File: rtl/flop_trio.sv
// flop_trio: three independent registered copies of a shared data input.
// Each channel has its own register so that none of them can be merged with another.
module flop_trio #(
  parameter int unsigned size = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] d,
  output logic [size-1:0] q1,
  output logic [size-1:0] q2,
  output logic [size-1:0] q3
);

  logic [size-1:0] r_q1;
  logic [size-1:0] r_q2;
  logic [size-1:0] r_q3;

  // Channel 1 register: synchronous clear has priority over the load of d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
    end else begin
      r_q1 <= d;
    end
  end

  // Channel 2 register: synchronous clear has priority over the load of d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q2 <= '0;
    end else begin
      r_q2 <= d;
    end
  end

  // Channel 3 register: synchronous clear has priority over the load of d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q3 <= '0;
    end else begin
      r_q3 <= d;
    end
  end

  assign q1 = r_q1;
  assign q2 = r_q2;
  assign q3 = r_q3;

endmodule

// File: tb/tb_flop_trio.sv
// Self-checking bench for flop_trio, exercising a 4-bit and a 1-bit build side by side.
module tb_flop_trio;

  logic       clk;
  logic       rst;
  logic [3:0] d4;
  logic [3:0] q1_4, q2_4, q3_4;
  logic [0:0] d1;
  logic [0:0] q1_1, q2_1, q3_1;

  int checks;
  int errors;

  // Reference model: the value each output should show is the value presented at the
  // most recent rising edge (zero if reset was high then). Kept as a history of edges.
  logic [3:0] hist4[$];
  logic [0:0] hist1[$];

  flop_trio #(.size(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .d   (d4),
    .q1  (q1_4),
    .q2  (q2_4),
    .q3  (q3_4)
  );

  flop_trio #(.size(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .d   (d1),
    .q1  (q1_1),
    .q2  (q2_1),
    .q3  (q3_1)
  );

  // Free-running two-valued clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  // Record what the model says each build must capture at this rising edge.
  always @(posedge clk) begin
    hist4.push_back(rst ? 4'b0000 : d4);
    hist1.push_back(rst ? 1'b0 : d1);
  end

  function automatic logic rand_4state();
    logic r;
    case ($urandom_range(3))
      0:       r = 1'b0;
      1:       r = 1'b1;
      2:       r = 1'bx;
      default: r = 1'bz;
    endcase
    return r;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v);
    rst = r;
    d4  = v;
    d1  = v[0];
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b1, 4'b1010);
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== 12'h000) begin
      errors++;
      $display("FAIL reset4 q1=%b q2=%b q3=%b want=0000", q1_4, q2_4, q3_4);
    end
    checks++;
    if ({q1_1, q2_1, q3_1} !== 3'b000) begin
      errors++;
      $display("FAIL reset1 q1=%b q2=%b q3=%b want=0", q1_1, q2_1, q3_1);
    end
  endtask

  task automatic test_hold_midcycle();
    @(negedge clk);
    drive(1'b0, 4'b0110);
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b0110}}) begin
      errors++;
      $display("FAIL load0110 q1=%b q2=%b q3=%b want=0110", q1_4, q2_4, q3_4);
    end
    #1 drive(1'b0, 4'b1001);
    @(negedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b0110}}) begin
      errors++;
      $display("FAIL hold0110 q1=%b q2=%b q3=%b want=0110", q1_4, q2_4, q3_4);
    end
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b1001}}) begin
      errors++;
      $display("FAIL load1001 q1=%b q2=%b q3=%b want=1001", q1_4, q2_4, q3_4);
    end
    checks++;
    if ({q1_1, q2_1, q3_1} !== 3'b111) begin
      errors++;
      $display("FAIL load1001_1bit q1=%b q2=%b q3=%b want=1", q1_1, q2_1, q3_1);
    end
  endtask

  task automatic test_four_state();
    logic [3:0] want;
    @(negedge clk);
    drive(1'b0, 4'b01xz);
    want = d4;
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{want}}) begin
      errors++;
      $display("FAIL fourstate q1=%b q2=%b q3=%b want=%b", q1_4, q2_4, q3_4, want);
    end
  endtask

  task automatic test_size1_seq();
    logic [3:0] seq;
    logic       v;
    seq = 4'b01xz;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      d1  = seq[3-i];
      v   = d1;
      @(posedge clk); #1;
      checks++;
      if ({q1_1, q2_1, q3_1} !== {3{v}}) begin
        errors++;
        $display("FAIL seq1_edge%0d q1=%b q2=%b q3=%b want=%b", i, q1_1, q2_1, q3_1, v);
      end
      @(negedge clk); #1;
      checks++;
      if ({q1_1, q2_1, q3_1} !== {3{v}}) begin
        errors++;
        $display("FAIL seq1_fall%0d q1=%b q2=%b q3=%b want=%b", i, q1_1, q2_1, q3_1, v);
      end
    end
  endtask

  task automatic test_rst_timing();
    @(negedge clk);
    drive(1'b0, 4'b1111);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b1111}}) begin
      errors++;
      $display("FAIL rst_no_async q1=%b q2=%b q3=%b want=1111", q1_4, q2_4, q3_4);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b1111}}) begin
      errors++;
      $display("FAIL rst_pulse_between q1=%b q2=%b q3=%b want=1111", q1_4, q2_4, q3_4);
    end
    @(negedge clk);
    drive(1'b1, 4'b1111);
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== 12'h000) begin
      errors++;
      $display("FAIL rst_priority q1=%b q2=%b q3=%b want=0000", q1_4, q2_4, q3_4);
    end
    @(negedge clk);
    drive(1'b0, 4'b0101);
    @(posedge clk); #1;
    checks++;
    if ({q1_4, q2_4, q3_4} !== {3{4'b0101}}) begin
      errors++;
      $display("FAIL rst_release q1=%b q2=%b q3=%b want=0101", q1_4, q2_4, q3_4);
    end
  endtask

  task automatic test_random(input int n);
    logic [3:0] v;
    logic [3:0] want4;
    logic [0:0] want1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) v[b] = rand_4state();
      rst = ($urandom_range(9) == 0);
      d4  = v;
      d1  = rand_4state();
      @(posedge clk); #1;
      want4 = hist4[$];
      want1 = hist1[$];
      checks++;
      if ({q1_4, q2_4, q3_4} !== {3{want4}}) begin
        errors++;
        $display("FAIL rand4_c%0d q1=%b q2=%b q3=%b want=%b", c, q1_4, q2_4, q3_4, want4);
      end
      checks++;
      if ({q1_1, q2_1, q3_1} !== {3{want1}}) begin
        errors++;
        $display("FAIL rand1_c%0d q1=%b q2=%b q3=%b want=%b", c, q1_1, q2_1, q3_1, want1);
      end
      #2;
      for (int b = 0; b < 4; b++) v[b] = rand_4state();
      d4  = v;
      d1  = rand_4state();
      rst = ($urandom_range(1) == 0);
      #1;
      checks++;
      if ({q1_4, q2_4, q3_4, q1_1, q2_1, q3_1} !== {{3{want4}}, {3{want1}}}) begin
        errors++;
        $display("FAIL rand_hold_c%0d q4=%b/%b/%b q1b=%b/%b/%b want=%b/%b",
                 c, q1_4, q2_4, q3_4, q1_1, q2_1, q3_1, want4, want1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 4'b0000);
    test_reset();
    test_hold_midcycle();
    test_four_state();
    test_size1_seq();
    test_rst_timing();
    test_random(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
